// File: rtl/apb_pkg.sv
// Shared types and widths for the APB requester and its timeout counter.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 4;
    localparam int unsigned APB_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  error;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Saturating wait-state counter; flags the cycle on which the count reaches TIMEOUT.
module apb_timeout_ctr
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Expiry is flagged while the count is one short, so the abort lands on the edge it reaches TIMEOUT.
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c_o = (TIMEOUT != 32'd0) && enable_i && (count_q == LIMIT);

endmodule

// File: rtl/apb_requester.sv
// APB initiator: turns a valid/ready command into a SETUP/ACCESS transfer and
// returns the completion (or a timeout abort) on a held response slot.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR
);

    apb_state_e        state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    apb_rsp_t          rsp_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;

    logic accept_c;
    logic wait_c;
    logic expired_c;

    assign accept_c = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    assign wait_c   = (state_q == ACCESS) && !PREADY;

    apb_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .clk         (PCLK),
        .rst         (PRESET),
        .clear_i     (accept_c),
        .enable_i    (wait_c),
        .expired_c_o (expired_c)
    );

    // Transfer sequencing; every bus and response output is a register of this block.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        state_q     <= SETUP;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        pwrite_q    <= cmd_write;
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_write ? cmd_wdata : '0;
                    end else if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_q       <= '0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cmd_ready_q <= !rsp_valid_q;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    // PREADY is checked first so a completion on the expiry cycle is not lost.
                    if (PREADY || expired_c) begin
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_q.rdata   <= (PREADY && !pwrite_q) ? APB_DATA_W'(PRDATA) : '0;
                        rsp_q.error   <= PREADY ? PSLVERR : 1'b1;
                        rsp_q.timeout <= !PREADY;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        pwrite_q      <= 1'b0;
                        paddr_q       <= '0;
                        pwdata_q      <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_error   = rsp_q.error;
    assign rsp_timeout = rsp_q.timeout;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed and randomized checks of apb_requester against a transaction-level model.
module tb_apb_requester;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 128;
    localparam int unsigned TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    always #5 PCLK = ~PCLK;

    apb_requester #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .CNT_W   (8)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR)
    );

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus_idle(input string tag);
        chk1({tag, "_psel"},    PSELx,   1'b0);
        chk1({tag, "_penable"}, PENABLE, 1'b0);
        chk1({tag, "_pwrite"},  PWRITE,  1'b0);
        chkw({tag, "_paddr"},   DW'(PADDR), '0);
        chkw({tag, "_pwdata"},  PWDATA,  '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bus_idle(tag);
        chk1({tag, "_cmd_ready"},   cmd_ready,   1'b0);
        chk1({tag, "_rsp_valid"},   rsp_valid,   1'b0);
        chkw({tag, "_rsp_rdata"},   rsp_rdata,   '0);
        chk1({tag, "_rsp_error"},   rsp_error,   1'b0);
        chk1({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
    endtask

    // One full transaction, entered and left at a negedge with the requester idle.
    // The expected outcome is derived from the wait count alone: a completer that
    // stays busy for TO or more ACCESS cycles yields a timeout after exactly TO cycles.
    task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int unsigned waits,
                           input logic [DW-1:0] rd, input logic serr, input int unsigned hold);
        logic          timed;
        int unsigned   n_acc;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_wd;
        logic          exp_err;
        timed   = (TO != 0) && (waits >= TO);
        n_acc   = timed ? TO : waits + 1;
        exp_rd  = (timed || wr) ? '0 : rd;
        exp_wd  = wr ? wd : '0;
        exp_err = timed | serr;

        chk1({tag, "_idle_cmd_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        rsp_ready = 1'b0;
        @(negedge PCLK);

        chk1({tag, "_setup_psel"},      PSELx,     1'b1);
        chk1({tag, "_setup_penable"},   PENABLE,   1'b0);
        chk1({tag, "_setup_pwrite"},    PWRITE,    wr);
        chkw({tag, "_setup_paddr"},     DW'(PADDR), DW'(addr));
        chkw({tag, "_setup_pwdata"},    PWDATA,    exp_wd);
        chk1({tag, "_setup_cmd_ready"}, cmd_ready, 1'b0);
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = rand_data();

        for (int unsigned k = 0; k < n_acc; k++) begin
            @(negedge PCLK);
            chk1({tag, "_acc_psel"},      PSELx,     1'b1);
            chk1({tag, "_acc_penable"},   PENABLE,   1'b1);
            chk1({tag, "_acc_pwrite"},    PWRITE,    wr);
            chkw({tag, "_acc_paddr"},     DW'(PADDR), DW'(addr));
            chkw({tag, "_acc_pwdata"},    PWDATA,    exp_wd);
            chk1({tag, "_acc_rsp_valid"}, rsp_valid, 1'b0);
            if (!timed && (k == waits)) begin
                PREADY  = 1'b1;
                PRDATA  = rd;
                PSLVERR = serr;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = rand_data();
                PSLVERR = 1'b1;
            end
        end
        @(negedge PCLK);
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        PRDATA  = rand_data();

        for (int unsigned h = 0; h <= hold; h++) begin
            chk1({tag, "_rsp_valid"},   rsp_valid,   1'b1);
            chkw({tag, "_rsp_rdata"},   rsp_rdata,   exp_rd);
            chk1({tag, "_rsp_error"},   rsp_error,   exp_err);
            chk1({tag, "_rsp_timeout"}, rsp_timeout, timed);
            chk1({tag, "_rsp_cmd_ready"}, cmd_ready, 1'b0);
            chk_bus_idle({tag, "_rsp"});
            if (h == hold) begin
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
            end else begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom);
                cmd_addr  = AW'($urandom);
                cmd_wdata = rand_data();
                rsp_ready = 1'b0;
            end
            @(negedge PCLK);
        end
        rsp_ready = 1'b0;
        PSLVERR   = 1'b0;
        chk1({tag, "_done_rsp_valid"}, rsp_valid, 1'b0);
        chk1({tag, "_done_cmd_ready"}, cmd_ready, 1'b1);
        chk1({tag, "_done_psel"},      PSELx,     1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        repeat (2) @(negedge PCLK);
        chk_all_zero("reset");
        PRESET = 1'b0;
        @(negedge PCLK);
        chk1("post_reset_cmd_ready", cmd_ready, 1'b1);

        run_txn("wr_zero_wait", 1'b1, 4'h3, {16{8'hA5}}, 0, '0, 1'b0, 0);
        run_txn("rd_two_wait", 1'b0, 4'h7, rand_data(), 2, DW'(16'h1234), 1'b0, 0);
        run_txn("rd_slverr", 1'b0, 4'hF, rand_data(), 1, rand_data(), 1'b1, 0);
        run_txn("rd_err_ignored", 1'b0, 4'hE, rand_data(), 3, rand_data(), 1'b0, 0);
        run_txn("rd_timeout", 1'b0, 4'h5, rand_data(), 10, rand_data(), 1'b0, 0);
        run_txn("wr_timeout_exact", 1'b1, 4'h6, rand_data(), TO, rand_data(), 1'b0, 0);
        run_txn("wr_backpressure", 1'b1, 4'h9, rand_data(), 1, rand_data(), 1'b0, 5);

        // Reset during a wait state: bus drops, no response survives.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'h2;
        cmd_wdata = rand_data();
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk1("rst_mid_penable", PENABLE, 1'b1);
        PREADY = 1'b0;
        PRESET = 1'b1;
        @(negedge PCLK);
        chk_all_zero("rst_mid");
        PRESET = 1'b0;
        @(negedge PCLK);
        chk1("rst_mid_release_cmd_ready", cmd_ready, 1'b1);
        repeat (3) begin
            @(negedge PCLK);
            chk1("rst_mid_no_rsp", rsp_valid, 1'b0);
            chk1("rst_mid_no_psel", PSELx, 1'b0);
        end
        run_txn("after_reset", 1'b0, 4'h2, rand_data(), 0, rand_data(), 1'b0, 1);

        for (int i = 0; i < 24; i++) begin
            run_txn("rand", 1'($urandom), AW'($urandom), rand_data(),
                    $urandom_range(0, 6), rand_data(), 1'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
